// File: rtl/ctr_sequencer_if.sv
// ============================================================================
// Module      : ctr_sequencer_if
// Description : Signal bundle between the interval-timer controller and its
//               surroundings (control register file and counter chain).
//               slave  : the controller side (ctr_sequencer)
//               master : the side that issues commands and owns the counter
//               Commands : start, stop, hold, preset, dir, mode, reps, irq_ack
//               Counter  : cq, mxmn in; cin, load_, ent_, ud out
//               Status   : busy, done, irq, count
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ctr_sequencer_if #(
   parameter int WIDTH = 4,
   parameter int RW    = 8
);
   logic             start;
   logic             stop;
   logic             hold;
   logic [WIDTH-1:0] preset;
   logic             dir;
   logic             mode;
   logic [RW-1:0]    reps;
   logic             irq_ack;
   logic [WIDTH-1:0] cq;
   logic             mxmn;
   logic [WIDTH-1:0] cin;
   logic             load_;
   logic             ent_;
   logic             ud;
   logic             busy;
   logic             done;
   logic             irq;
   logic [WIDTH-1:0] count;

   modport slave (
      input  start, stop, hold, preset, dir, mode, reps, irq_ack, cq, mxmn,
      output cin, load_, ent_, ud, busy, done, irq, count
   );

   modport master (
      output start, stop, hold, preset, dir, mode, reps, irq_ack, cq, mxmn,
      input  cin, load_, ent_, ud, busy, done, irq, count
   );
endinterface

`default_nettype wire

// File: rtl/ctr_sequencer.sv
// ============================================================================
// Module      : ctr_sequencer
// Description : Programmable interval-timer controller for an external
//               cascaded up/down counter chain (am25ls191 style).
//               One-shot / auto-reload with repeat count, hold, stop and a
//               sticky interrupt.
//   clk  : system clock, rising edge
//   rst  : asynchronous reset, active-high
//   bus  : ctr_sequencer_if.slave
//          in  : start, stop, hold, preset, dir, mode, reps, irq_ack, cq, mxmn
//          out : cin, load_, ent_, ud, busy, done, irq, count
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctr_sequencer #(
   parameter int WIDTH = 4,
   parameter int RW    = 8
) (
   input  wire logic       clk,
   input  wire logic       rst,
   ctr_sequencer_if.slave  bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;

   logic [1:0]       r_state;
   logic [1:0]       w_next_state;

   logic [WIDTH-1:0] r_preset;
   logic             r_dir;
   logic             r_mode;
   logic [RW-1:0]    r_reps;
   logic [RW-1:0]    r_rep_cnt;
   logic             r_done;
   logic             r_irq;

   logic             w_restart;
   logic             w_term;
   logic             w_last;
   logic             w_reload;
   logic             w_load_n;
   logic             w_ent_n;
   logic             w_done_next;
   logic             w_rep_inc;

   // stop dominates start; start dominates everything the current state does
   assign w_restart = bus.start & ~bus.stop;
   // hold masks the terminal flag so a frozen counter never completes
   assign w_term    = bus.mxmn & ~bus.hold;
   // reps == 0 means reload forever, so there is never a last period
   assign w_last    = (r_reps != '0) && (r_rep_cnt == (r_reps - RW'(1)));
   assign w_reload  = r_mode & ~w_last;

   assign w_done_next = (r_state == S_RUN) & ~bus.stop & ~bus.start & w_term;
   assign w_rep_inc   = w_done_next & w_reload;

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      w_next_state = r_state;
      if (bus.stop) begin
         w_next_state = S_IDLE;
      end else if (bus.start) begin
         w_next_state = S_LOAD;
      end else begin
         case (r_state)
            S_IDLE:  w_next_state = S_IDLE;
            S_LOAD:  w_next_state = S_RUN;
            S_RUN:   if (w_term && !w_reload) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
         endcase
      end
   end

   // -------------------------------------------------------------- outputs
   // The counter pins are combinational so a terminal cycle can freeze the
   // counter (ent_=1) or reload it (load_=0) at the very edge it ends on.
   always_comb begin
      w_load_n = 1'b1;
      w_ent_n  = 1'b1;
      if (!bus.stop && !bus.start) begin
         case (r_state)
            S_LOAD: begin
               w_load_n = 1'b0;
               w_ent_n  = 1'b0;
            end
            S_RUN: begin
               if (!bus.hold) begin
                  if (!bus.mxmn) begin
                     w_ent_n = 1'b0;
                  end else if (w_reload) begin
                     w_load_n = 1'b0;
                     w_ent_n  = 1'b0;
                  end
               end
            end
            default: begin
               w_load_n = 1'b1;
               w_ent_n  = 1'b1;
            end
         endcase
      end
   end

   // ------------------------------------------------- configuration / status
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_preset  <= '0;
         r_dir     <= 1'b0;
         r_mode    <= 1'b0;
         r_reps    <= '0;
         r_rep_cnt <= '0;
         r_done    <= 1'b0;
         r_irq     <= 1'b0;
      end else begin
         if (w_restart) begin
            r_preset  <= bus.preset;
            r_dir     <= bus.dir;
            r_mode    <= bus.mode;
            r_reps    <= bus.reps;
            r_rep_cnt <= '0;
         end else if (w_rep_inc) begin
            r_rep_cnt <= r_rep_cnt + RW'(1);
         end
         r_done <= w_done_next;
         // done in the same cycle as irq_ack still leaves irq set
         r_irq  <= r_done | (r_irq & ~bus.irq_ack);
      end
   end

   assign bus.cin   = r_preset;
   assign bus.ud    = r_dir;
   assign bus.load_ = w_load_n;
   assign bus.ent_  = w_ent_n;
   assign bus.busy  = (r_state != S_IDLE);
   assign bus.done  = r_done;
   assign bus.irq   = r_irq;
   assign bus.count = bus.cq;

endmodule

`default_nettype wire

// File: tb/tb_ctr_sequencer.sv
// ============================================================================
// Module      : tb_ctr_sequencer
// Description : Self-checking bench for ctr_sequencer. Holds a behavioural
//               model of the external counter chain and an abstract model of
//               the timer (position within period, periods completed).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ctr_sequencer;

   localparam int WIDTH = 4;
   localparam int RW    = 8;
   localparam int MAXV  = (1 << WIDTH) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;

   ctr_sequencer_if #(.WIDTH(WIDTH), .RW(RW)) u_if ();

   ctr_sequencer #(.WIDTH(WIDTH), .RW(RW)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
   );

   always #5 clk = ~clk;

   // external counter chain, driven by the DUT pins
   logic [WIDTH-1:0] cnt_q = '0;
   always @(posedge clk) begin
      if (!u_if.load_)     cnt_q <= u_if.cin;
      else if (!u_if.ent_) cnt_q <= u_if.ud ? cnt_q - 1'b1 : cnt_q + 1'b1;
   end
   assign u_if.cq   = cnt_q;
   assign u_if.mxmn = u_if.ud ? (cnt_q == '0) : (cnt_q == '1);

   int n_chk = 0;
   int n_err = 0;

   // pending stimulus, applied at the falling edge
   bit p_rst = 1'b1;
   int p_preset = 0;
   bit p_dir = 1'b0, p_mode = 1'b0;
   int p_reps = 0;
   bit p_start, p_stop, p_hold, p_ack;

   // abstract model
   bit m_busy, m_in_load, m_done, m_irq, m_dir, m_mode;
   int m_preset, m_reps, m_pos, m_periods;
   int m_cq = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_in_load = 0; m_done = 0; m_irq = 0;
      m_dir = 0; m_mode = 0; m_preset = 0; m_reps = 0;
      m_pos = 0; m_periods = 0;
   endtask

   task automatic model_step();
      int len;
      bit term, last, e_ld, e_en;
      if (rst) model_reset();
      len  = m_dir ? m_preset + 1 : (MAXV - m_preset) + 1;
      term = m_busy && !m_in_load && !p_hold && (m_pos == len - 1);
      last = (m_reps != 0) && (m_periods == m_reps - 1);
      e_ld = 1; e_en = 1;
      if (!p_stop && !p_start && m_busy) begin
         if (m_in_load) begin e_ld = 0; e_en = 0; end
         else if (p_hold) begin e_ld = 1; e_en = 1; end
         else if (!term) e_en = 0;
         else if (m_mode && !last) begin e_ld = 0; e_en = 0; end
      end
      chk("ent_",  int'(u_if.ent_),  int'(e_en));
      chk("load_", int'(u_if.load_), int'(e_ld));
      chk("busy",  int'(u_if.busy),  int'(m_busy));
      chk("done",  int'(u_if.done),  int'(m_done));
      chk("irq",   int'(u_if.irq),   int'(m_irq));
      chk("cin",   int'(u_if.cin),   m_preset);
      chk("ud",    int'(u_if.ud),    int'(m_dir));
      chk("count", int'(u_if.count), m_cq);
      if (!rst) begin
         m_irq  = m_done || (m_irq && !p_ack);
         m_done = m_busy && !m_in_load && !p_stop && !p_start && term;
         if (!e_ld)      m_cq = m_preset;
         else if (!e_en) m_cq = (m_dir ? m_cq - 1 : m_cq + 1) & MAXV;
         if (p_stop) begin
            m_busy = 0; m_in_load = 0;
         end else if (p_start) begin
            m_busy = 1; m_in_load = 1; m_pos = 0; m_periods = 0;
            m_preset = p_preset; m_dir = p_dir; m_mode = p_mode; m_reps = p_reps;
         end else if (m_busy) begin
            if (m_in_load) begin m_in_load = 0; m_pos = 0; end
            else if (p_hold) ;
            else if (!term) m_pos++;
            else if (m_mode && !last) begin m_periods++; m_pos = 0; end
            else m_busy = 0;
         end
      end
   endtask

   task automatic cyc(input bit st, input bit sp, input bit hd, input bit ack);
      @(negedge clk);
      p_start = st; p_stop = sp; p_hold = hd; p_ack = ack;
      rst          = p_rst;
      u_if.start   = st;
      u_if.stop    = sp;
      u_if.hold    = hd;
      u_if.irq_ack = ack;
      u_if.preset  = WIDTH'(p_preset);
      u_if.dir     = p_dir;
      u_if.mode    = p_mode;
      u_if.reps    = RW'(p_reps);
      #2;
      model_step();
   endtask

   task automatic cfg(input int pr, input bit d, input bit md, input int rp);
      p_preset = pr; p_dir = d; p_mode = md; p_reps = rp;
   endtask

   int ndone;

   initial begin
      u_if.start = 0; u_if.stop = 0; u_if.hold = 0; u_if.irq_ack = 0;
      u_if.preset = '0; u_if.dir = 0; u_if.mode = 0; u_if.reps = '0;
      model_reset();
      repeat (3) cyc(0, 0, 0, 0);
      chk("rst_load_", int'(u_if.load_), 1);
      chk("rst_busy", int'(u_if.busy), 0);
      p_rst = 0;
      cyc(0, 0, 0, 0);

      // down one-shot from 5
      cfg(5, 1, 0, 0);
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0); chk("t1_load", int'(u_if.load_), 0);
      for (int i = 0; i < 6; i++) begin
         cyc(0, 0, 0, 0); chk("t1_cq", int'(u_if.count), 5 - i);
      end
      chk("t1_ent_term", int'(u_if.ent_), 1);
      cyc(0, 0, 0, 0); chk("t1_done", int'(u_if.done), 1);
      chk("t1_busy", int'(u_if.busy), 0);
      cyc(0, 0, 0, 0); chk("t1_irq", int'(u_if.irq), 1);
      chk("t1_cq_hold", int'(u_if.count), 0);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 0); chk("t1_irq_clr", int'(u_if.irq), 0);

      // up auto-reload 13, three periods
      cfg(13, 0, 1, 3);
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         cyc(0, 0, 0, 0); ndone += int'(u_if.done);
      end
      chk("t2_ndone", ndone, 3);
      chk("t2_cq", int'(u_if.count), 15);
      chk("t2_busy", int'(u_if.busy), 0);

      // infinite reload down from 2, stop at cq=1 in the third period
      cfg(2, 1, 1, 0);
      cyc(1, 0, 0, 1);
      cyc(0, 0, 0, 0);
      ndone = 0;
      for (int i = 0; i < 7; i++) begin
         cyc(0, 0, 0, 0); ndone += int'(u_if.done);
      end
      chk("t3_ndone", ndone, 2);
      cyc(0, 1, 0, 0); chk("t3_stop_ent_", int'(u_if.ent_), 1);
      chk("t3_stop_cq", int'(u_if.count), 1);
      cyc(0, 0, 0, 0); chk("t3_idle", int'(u_if.busy), 0);
      chk("t3_nodone", int'(u_if.done), 0);
      cyc(0, 0, 0, 0); chk("t3_frozen", int'(u_if.count), 1);

      // hold 4 cycles at cq=3, down one-shot from 6
      cfg(6, 1, 0, 0);
      cyc(1, 0, 0, 1);
      cyc(0, 0, 0, 0);
      repeat (3) cyc(0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 1, 0); chk("t4_held", int'(u_if.count), 3);
      end
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
         cyc(0, 0, 0, 0); ndone += int'(u_if.done);
         if (i == 3) chk("t4_term_cq", int'(u_if.count), 0);
      end
      chk("t4_ndone", ndone, 1);

      // hold while sitting on the terminal value
      cfg(1, 1, 0, 0);
      cyc(1, 0, 0, 1);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 1, 0); chk("t4b_nodone", int'(u_if.done), 0);
      end
      cyc(0, 0, 0, 0); chk("t4b_term_ent_", int'(u_if.ent_), 1);
      cyc(0, 0, 0, 0); chk("t4b_done", int'(u_if.done), 1);

      // restart at cq=4 with new preset 9 counting up
      cfg(7, 1, 0, 0);
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
      repeat (3) cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0); chk("t5_cq4", int'(u_if.count), 4);
      cfg(9, 0, 0, 0);
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0); chk("t5_load", int'(u_if.load_), 0);
      for (int i = 0; i < 7; i++) begin
         cyc(0, 0, 0, 0); chk("t5_cq", int'(u_if.count), 9 + i);
      end
      cyc(0, 0, 0, 0); chk("t5_done", int'(u_if.done), 1);
      cfg(3, 1, 0, 0);
      cyc(1, 1, 0, 0);
      cyc(0, 0, 0, 0); chk("t5_startstop", int'(u_if.busy), 0);

      // asynchronous reset mid-run; irq still set from the run above
      cfg(8, 1, 0, 0);
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
      repeat (3) cyc(0, 0, 0, 0);
      chk("t6_pre_irq", int'(u_if.irq), 1);
      @(posedge clk);
      #2;
      rst = 1'b1; p_rst = 1'b1;
      #1;
      chk("t6_load_", int'(u_if.load_), 1);
      chk("t6_ent_", int'(u_if.ent_), 1);
      chk("t6_busy", int'(u_if.busy), 0);
      chk("t6_irq", int'(u_if.irq), 0);
      model_reset();
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      p_rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 0); chk("t6_quiet", int'(u_if.count), 5);
      end

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         bit st, sp, hd, ak;
         st = ($urandom_range(0, 99) < 4);
         sp = ($urandom_range(0, 199) < 3);
         hd = ($urandom_range(0, 99) < 15);
         ak = ($urandom_range(0, 99) < 10);
         if (st)
            cfg($urandom_range(0, MAXV), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, 3));
         cyc(st, sp, hd, ak);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ctr_sequencer.md
Name: ctr_sequencer

Overview:
- Programmable interval-timer controller that drives one cascaded am25ls191-style up/down counter chain (WIDTH bits) through its in/load_/ent_/ud pins and watches its q/mxmn outputs.
- Supports one-shot and auto-reload operation with a repeat count, hold, stop and a sticky interrupt.
- Sits between the microcode/control register file and the counter datapath. The counter itself stays external.

Parameters:
- WIDTH, 4, width of the counter chain (preset, cin, cq).
- RW, 8, width of the repeat counter (reps).

Ports:
- clk  input  1  system clock, all state changes on rising edge
- rst  input  1  asynchronous reset, active-high
- start  input  1  command pulse: latch preset/dir/mode/reps and begin
- stop  input  1  abort to IDLE
- hold  input  1  level: freeze counting while in RUN
- preset  input  WIDTH  load value
- dir  input  1  0=count up, 1=count down (copied to ud)
- mode  input  1  0=one-shot, 1=auto-reload
- reps  input  RW  auto-reload period count; 0=infinite
- irq_ack  input  1  clears irq
- cq  input  WIDTH  counter q (for status/readback only)
- mxmn  input  1  counter terminal flag: all-ones while ud=0, all-zeros while ud=1 (combinational in counter)
- cin  output  WIDTH  counter parallel load data
- load_  output  1  counter load, active-low
- ent_  output  1  counter enable, active-low
- ud  output  1  counter direction
- busy  output  1  high in LOAD or RUN
- done  output  1  one-cycle pulse per completed period
- irq  output  1  sticky, set by done
- count  output  WIDTH  mirror of cq

Behaviour:
- Reset (async, any state): state=IDLE; cin=0, ud=0, load_=1, ent_=1, busy=0, done=0, irq=0; internal preset/mode/reps/rep-counter cleared.
- States: IDLE, LOAD, RUN.
- IDLE: load_=1, ent_=1. start -> LOAD. Preset, dir, mode and reps are latched at that edge. cin and ud come from the latched registers.
- LOAD (exactly 1 cycle): load_=0, ent_=0. Counter holds preset after the edge ending LOAD. Next state is RUN.
- RUN, with term = mxmn & ~hold:
  - hold=1: ent_=1, load_=1. Counter frozen, terminal ignored, state unchanged.
  - ~term: ent_=0, load_=1. Counter counts.
  - term & one-shot: ent_=1 combinationally, so the counter stays at terminal. Next state is IDLE; done=1 next cycle.
  - term & reload & not last period: ent_=0, load_=0, so the preset reloads. Rep counter +1; done=1 next cycle; stay in RUN.
  - term & reload & last period (reps!=0, rep counter == reps-1): behaves like one-shot terminal. Counter held at terminal, go to IDLE, done pulse.
- Period timing: one period spans |terminal - preset|+1 RUN cycles. Example: down from P to 0 takes P+1 cycles.
- done is registered: high exactly the cycle after the terminal cycle, low otherwise.
- irq: set on done, cleared on irq_ack. Simultaneous done and irq_ack leaves irq=1.
- start while LOAD/RUN: restart. Relatch inputs, go to LOAD, rep counter cleared.
- stop: from any state go to IDLE next edge. ent_=1 and load_=1 combinationally in the stop cycle. No done pulse. Stop wins over start and over terminal in the same cycle.
- busy = (state != IDLE), registered with state.
- Preset equal to terminal (e.g. 0 counting down): the first RUN cycle is terminal, giving a 1-cycle period.
- Counter wrap never occurs under controller command. The terminal value is always either held or reloaded.
- count = cq, passed through combinationally. rco_ of the counter is not used.

Test Plan:
- WIDTH=4, down one-shot, preset=5, start pulse: LOAD 1 cycle; then cq=5,4,3,2,1,0 over 6 RUN cycles. ent_=1 in the cq=0 cycle, one done pulse, busy drops, cq stays 0, irq=1 until irq_ack.
- Up auto-reload, preset=13, reps=3: cq cycles 13,14,15 three times (9 RUN cycles), giving 3 done pulses 3 cycles apart. After the 3rd, state is IDLE and cq holds 15.
- Reload, reps=0, down, preset=2: cq sequence 2,1,0,2,1,0,... continues indefinitely with done every 3 cycles. Stop mid-period at cq=1 -> IDLE, cq frozen at 1, no done.
- Hold asserted for 4 cycles at cq=3 (down one-shot, preset=6): cq stays 3 for 4 cycles. Terminal reached 4 cycles later than unheld; done count still 1. Also hold while cq=0: no done until hold released.
- Start issued at cq=4 during a run with new preset=9, dir=0: LOAD follows, then cq=9,10,...,15 and done. Simultaneous start+stop -> IDLE.
- rst asserted mid-RUN, asynchronously between edges: load_=1, ent_=1, busy=0, irq=0 immediately. No activity until the next start.
